// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared core-wide definitions: bus widths, the read arbiter state encoding and
// the AXI4-lite ARPROT attributes used for data and instruction reads.
// No ports (package).
// -----------------------------------------------------------------------------
package core_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;

    // Read arbiter control states: wait for a request, drive the address
    // phase, then pass the single outstanding response through.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_ADDR = 2'b01,
        ARB_DATA = 2'b10
    } arb_state_t;

    // ARPROT[2] marks an instruction access; data reads are unprivileged,
    // secure, data.
    localparam logic [2:0] ARPROT_DATA  = 3'b000;
    localparam logic [2:0] ARPROT_INSTR = 3'b100;

endpackage : core_pkg

// File: rtl/axil_read_arbiter_grant_select.sv
// -----------------------------------------------------------------------------
// arb_grant_select
// Combinational grant policy for the two-way read arbiter. Index 0 is the load
// path, index 1 is instruction fetch.
//
// Configuration macro: AXIL_ARB_ROUND_ROBIN_EN
//   defined   - round robin: on a tie the requester that was not served last
//               wins; a lone request is granted directly.
//   undefined - fixed priority: the load path always wins; last_grant ignored.
//
// Ports:
//   req[1:0]    in   request vector {fetch, load}
//   last_grant  in   index of the requester served most recently
//   gnt_valid   out  at least one request is present
//   gnt_idx     out  index of the selected requester
// -----------------------------------------------------------------------------
module arb_grant_select (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    assign gnt_valid = |req;

`ifdef AXIL_ARB_ROUND_ROBIN_EN
    // On a tie the turn passes away from whoever was served last; otherwise
    // the only active requester is chosen.
    assign gnt_idx = (&req) ? ~last_grant : req[1];
`else
    // Load path has strict priority; fetch only wins when it is alone.
    assign gnt_idx = ~req[0] & req[1];

    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

endmodule : arb_grant_select

// File: rtl/axil_read_arbiter.sv
// -----------------------------------------------------------------------------
// axil_read_arbiter
// Shares one AXI4-lite read master channel between the load path (s0) and the
// instruction fetch unit (s1). One transaction is outstanding at a time: a
// request is accepted in ARB_IDLE, its address is replayed on the master AR
// channel in ARB_ADDR, and the response is passed straight through to the
// granted requester in ARB_DATA. rdata/rresp are broadcast; only rvalid is
// steered. After every response the arbiter spends one cycle in ARB_IDLE.
//
// Configuration macro: AXIL_ARB_ROUND_ROBIN_EN (see arb_grant_select) selects
// round-robin instead of fixed load-path priority.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   s0_ar*/s0_r*             load-path AXI4-lite read slave port
//   s1_ar*/s1_r*             instruction-fetch AXI4-lite read slave port
//   m_araddr/m_arprot        master read address and protection
//   m_arvalid/m_arready      master address handshake
//   m_rdata/m_rresp          master read data and response code
//   m_rvalid/m_rready        master response handshake
// -----------------------------------------------------------------------------
module axil_read_arbiter
    import core_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_WIDTH,
    parameter int unsigned DATA_W = DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] s0_araddr,
    input  logic              s0_arvalid,
    output logic              s0_arready,
    output logic [DATA_W-1:0] s0_rdata,
    output logic [1:0]        s0_rresp,
    output logic              s0_rvalid,
    input  logic              s0_rready,

    input  logic [ADDR_W-1:0] s1_araddr,
    input  logic              s1_arvalid,
    output logic              s1_arready,
    output logic [DATA_W-1:0] s1_rdata,
    output logic [1:0]        s1_rresp,
    output logic              s1_rvalid,
    input  logic              s1_rready,

    output logic [ADDR_W-1:0] m_araddr,
    output logic [2:0]        m_arprot,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready
);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic              grant_q;
    logic              last_grant_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        arprot_q;

    logic              gnt_valid;
    logic              gnt_idx;
    logic              accept;
    logic              complete;
    logic              granted_rready;

    arb_grant_select u_grant_select (
        .req        ({s1_arvalid, s0_arvalid}),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every flop in
    // the design samples its inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and handshake outputs
    // -------------------------------------------------------------------------
    assign granted_rready = grant_q ? s1_rready : s0_rready;

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        complete   = 1'b0;
        s0_arready = 1'b0;
        s1_arready = 1'b0;
        m_arvalid  = 1'b0;
        m_rready   = 1'b0;
        s0_rvalid  = 1'b0;
        s1_rvalid  = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (gnt_valid) begin
                    accept     = 1'b1;
                    s0_arready = ~gnt_idx;
                    s1_arready = gnt_idx;
                    state_d    = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    state_d = ARB_DATA;
                end
            end
            ARB_DATA: begin
                m_rready  = granted_rready;
                s0_rvalid = ~grant_q & m_rvalid;
                s1_rvalid = grant_q & m_rvalid;
                if (m_rvalid && granted_rready) begin
                    complete = 1'b1;
                    state_d  = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        // While reset is asserted no handshake may complete on either side:
        // anything in flight is abandoned and the bus is reset with us.
        if (!rst) begin
            accept     = 1'b0;
            complete   = 1'b0;
            s0_arready = 1'b0;
            s1_arready = 1'b0;
            m_arvalid  = 1'b0;
            m_rready   = 1'b0;
            s0_rvalid  = 1'b0;
            s1_rvalid  = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Request capture and grant history
    // -------------------------------------------------------------------------
    // last_grant resets to the fetch unit so the first tie under round robin
    // goes to the load path.
    always_ff @(posedge clk) begin
        if (!rst) begin
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            arprot_q     <= ARPROT_DATA;
        end else begin
            if (accept) begin
                grant_q  <= gnt_idx;
                addr_q   <= gnt_idx ? s1_araddr : s0_araddr;
                arprot_q <= gnt_idx ? ARPROT_INSTR : ARPROT_DATA;
            end
            if (complete) begin
                last_grant_q <= grant_q;
            end
        end
    end

    // Address and protection come straight from the capture registers, so
    // they are stable for the whole address phase regardless of m_arready.
    assign m_araddr = addr_q;
    assign m_arprot = arprot_q;

    // Response payload is broadcast; only rvalid identifies the recipient.
    assign s0_rdata = m_rdata;
    assign s1_rdata = m_rdata;
    assign s0_rresp = m_rresp;
    assign s1_rresp = m_rresp;

endmodule : axil_read_arbiter

// File: tb/tb_axil_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axil_read_arbiter
// Self-checking bench for axil_read_arbiter. Requesters are modelled as a
// pending flag plus address per port; the expected winner of each
// arbitration comes from the grant rule applied to those flags and the
// index of the last requester served. Honours AXIL_ARB_ROUND_ROBIN_EN.
// -----------------------------------------------------------------------------
module tb_axil_read_arbiter;
    import core_pkg::*;

    localparam int unsigned AW = ADDR_WIDTH;
    localparam int unsigned DW = DATA_WIDTH;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] s0_araddr = '0, s1_araddr = '0;
    logic          s0_arvalid = 1'b0, s1_arvalid = 1'b0;
    logic          s0_arready, s1_arready;
    logic [DW-1:0] s0_rdata, s1_rdata;
    logic [1:0]    s0_rresp, s1_rresp;
    logic          s0_rvalid, s1_rvalid;
    logic          s0_rready = 1'b0, s1_rready = 1'b0;
    logic [AW-1:0] m_araddr;
    logic [2:0]    m_arprot;
    logic          m_arvalid;
    logic          m_arready = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic [1:0]    m_rresp = '0;
    logic          m_rvalid = 1'b0;
    logic          m_rready;

    axil_read_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .s0_araddr  (s0_araddr),
        .s0_arvalid (s0_arvalid),
        .s0_arready (s0_arready),
        .s0_rdata   (s0_rdata),
        .s0_rresp   (s0_rresp),
        .s0_rvalid  (s0_rvalid),
        .s0_rready  (s0_rready),
        .s1_araddr  (s1_araddr),
        .s1_arvalid (s1_arvalid),
        .s1_arready (s1_arready),
        .s1_rdata   (s1_rdata),
        .s1_rresp   (s1_rresp),
        .s1_rvalid  (s1_rvalid),
        .s1_rready  (s1_rready),
        .m_araddr   (m_araddr),
        .m_arprot   (m_arprot),
        .m_arvalid  (m_arvalid),
        .m_arready  (m_arready),
        .m_rdata    (m_rdata),
        .m_rresp    (m_rresp),
        .m_rvalid   (m_rvalid),
        .m_rready   (m_rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: who is waiting, with what address, and who was
    // served most recently (fetch after reset).
    bit            pend [2];
    logic [AW-1:0] pend_addr [2];
    int            model_last = 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here and
    // outputs are sampled a further #1 later, well away from either edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reqs();
        s0_arvalid = pend[0];
        s0_araddr  = pend[0] ? pend_addr[0] : '0;
        s1_arvalid = pend[1];
        s1_araddr  = pend[1] ? pend_addr[1] : '0;
    endtask

    // Winner according to the arbitration policy.
    function automatic int pick();
        if (pend[0] && pend[1]) begin
`ifdef AXIL_ARB_ROUND_ROBIN_EN
            return (model_last == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        return pend[0] ? 0 : 1;
    endfunction

    task automatic set_rready(input int g, input logic v);
        if (g == 0) begin
            s0_rready = v;
            s1_rready = 1'($urandom_range(0, 1));
        end else begin
            s1_rready = v;
            s0_rready = 1'($urandom_range(0, 1));
        end
    endtask

    // Runs one full transaction starting in an ARB_IDLE cycle. The served
    // requester either drops its request or (hold) immediately posts a new
    // one. obs_g is the requester the DUT actually acknowledged.
    task automatic serve(input int ar_dly, input int r_dly, input int rr_dly,
                         input logic [1:0] resp, input logic [DW-1:0] data,
                         input bit hold, output int obs_g);
        int            g;
        logic [AW-1:0] ea;
        logic [2:0]    ep;
        apply_reqs();
        #1;
        g  = pick();
        ea = pend_addr[g];
        ep = (g == 1) ? 3'b100 : 3'b000;
        obs_g = s1_arready ? 1 : 0;
        check("accept_s0_arready", 64'(s0_arready), 64'(g == 0));
        check("accept_s1_arready", 64'(s1_arready), 64'(g == 1));
        check("accept_m_arvalid", 64'(m_arvalid), 64'd0);
        step();
        if (hold) pend_addr[g] = pend_addr[g] + AW'('h10);
        else      pend[g] = 1'b0;
        apply_reqs();

        for (int i = 0; i < ar_dly; i++) begin
            m_arready = 1'b0;
            m_rvalid  = 1'($urandom_range(0, 1));
            #1;
            check("addr_wait_m_arvalid", 64'(m_arvalid), 64'd1);
            check("addr_wait_m_araddr", 64'(m_araddr), 64'(ea));
            check("addr_wait_m_arprot", 64'(m_arprot), 64'(ep));
            check("addr_wait_m_rready", 64'(m_rready), 64'd0);
            check("addr_wait_arready", 64'({s1_arready, s0_arready}), 64'd0);
            check("addr_wait_rvalid", 64'({s1_rvalid, s0_rvalid}), 64'd0);
            step();
        end
        m_rvalid  = 1'b0;
        m_arready = 1'b1;
        #1;
        check("addr_m_arvalid", 64'(m_arvalid), 64'd1);
        check("addr_m_araddr", 64'(m_araddr), 64'(ea));
        check("addr_m_arprot", 64'(m_arprot), 64'(ep));
        step();
        m_arready = 1'b0;

        for (int i = 0; i < r_dly; i++) begin
            s0_rready = 1'($urandom_range(0, 1));
            s1_rready = 1'($urandom_range(0, 1));
            #1;
            check("data_wait_rvalid", 64'({s1_rvalid, s0_rvalid}), 64'd0);
            check("data_wait_arready", 64'({s1_arready, s0_arready}), 64'd0);
            step();
        end

        m_rvalid = 1'b1;
        m_rdata  = data;
        m_rresp  = resp;
        for (int i = 0; i < rr_dly; i++) begin
            set_rready(g, 1'b0);
            #1;
            check("stall_m_rready", 64'(m_rready), 64'd0);
            check("stall_rvalid", 64'({s1_rvalid, s0_rvalid}), (g == 1) ? 64'd2 : 64'd1);
            step();
        end
        set_rready(g, 1'b1);
        #1;
        check("resp_m_rready", 64'(m_rready), 64'd1);
        check("resp_rvalid", 64'({s1_rvalid, s0_rvalid}), (g == 1) ? 64'd2 : 64'd1);
        check("resp_s0_rdata", 64'(s0_rdata), 64'(data));
        check("resp_s1_rdata", 64'(s1_rdata), 64'(data));
        check("resp_rresp", 64'((g == 1) ? s1_rresp : s0_rresp), 64'(resp));
        step();
        model_last = g;

        // Back in ARB_IDLE: a stray response beat must not be taken.
        s0_rready = 1'b1;
        s1_rready = 1'b1;
        #1;
        check("idle_m_rready", 64'(m_rready), 64'd0);
        check("idle_rvalid", 64'({s1_rvalid, s0_rvalid}), 64'd0);
        check("idle_m_arvalid", 64'(m_arvalid), 64'd0);
        m_rvalid  = 1'b0;
        s0_rready = 1'b0;
        s1_rready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        model_last = 1;
    endtask

    initial begin : main
        int            obs_g;
        int            exp_seq [4];
        int            ar_d, r_d, rr_d;
        logic [1:0]    resp;
        logic [DW-1:0] data;

        pend[0] = 1'b0;
        pend[1] = 1'b0;
        pend_addr[0] = '0;
        pend_addr[1] = '0;

        // ---- Reset, then idle with no requests ----
        rst = 1'b0;
        step();
        step();
        #1;
        check("rst_m_arvalid", 64'(m_arvalid), 64'd0);
        check("rst_m_rready", 64'(m_rready), 64'd0);
        check("rst_m_araddr", 64'(m_araddr), 64'd0);
        check("rst_m_arprot", 64'(m_arprot), 64'd0);
        check("rst_arready", 64'({s1_arready, s0_arready}), 64'd0);
        check("rst_rvalid", 64'({s1_rvalid, s0_rvalid}), 64'd0);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            #1;
            check("idle_no_req_m_arvalid", 64'(m_arvalid), 64'd0);
        end

        // ---- Single fetch ----
        pend[1] = 1'b1;
        pend_addr[1] = AW'('h4);
        serve(0, 0, 0, 2'b00, DW'('h0010_0093), 1'b0, obs_g);
        check("fetch_served", 64'(obs_g), 64'd1);

        // ---- Simultaneous requests present from reset ----
        pend[0] = 1'b1;
        pend_addr[0] = AW'('h100);
        pend[1] = 1'b1;
        pend_addr[1] = AW'('h8);
        apply_reqs();
        do_reset();
        serve(0, 0, 0, 2'b00, DW'($urandom), 1'b0, obs_g);
        check("simul_first_is_s0", 64'(obs_g), 64'd0);
        serve(0, 0, 0, 2'b00, DW'($urandom), 1'b0, obs_g);
        check("simul_second_is_s1", 64'(obs_g), 64'd1);

        // ---- Both held continuously for four transactions ----
`ifdef AXIL_ARB_ROUND_ROBIN_EN
        exp_seq = '{0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        pend[0] = 1'b1;
        pend_addr[0] = AW'('h200);
        pend[1] = 1'b1;
        pend_addr[1] = AW'('h300);
        for (int k = 0; k < 4; k++) begin
            serve(0, 0, 0, 2'b00, DW'($urandom), 1'b1, obs_g);
            check($sformatf("held_order_%0d", k), 64'(obs_g), 64'(exp_seq[k]));
        end
        for (int k = 0; k < 2; k++) begin
            if (pend[0] || pend[1]) serve(0, 0, 0, 2'b00, DW'($urandom), 1'b0, obs_g);
        end

        // ---- Backpressure on both channels ----
        pend[0] = 1'b1;
        pend_addr[0] = AW'('h40);
        serve(3, 0, 2, 2'b00, DW'('hCAFE_0001), 1'b0, obs_g);
        check("bp_served", 64'(obs_g), 64'd0);

        // ---- Error responses forwarded unmodified ----
        pend[0] = 1'b1;
        pend_addr[0] = AW'('h50);
        serve(0, 1, 0, 2'b10, DW'('hDEAD_0000), 1'b0, obs_g);
        pend[1] = 1'b1;
        pend_addr[1] = AW'('h60);
        serve(1, 0, 1, 2'b11, DW'('hDEAD_0001), 1'b0, obs_g);

        // ---- Reset while in ARB_DATA ----
        pend[0] = 1'b1;
        pend_addr[0] = AW'('h80);
        apply_reqs();
        #1;
        check("rstdata_accept", 64'(s0_arready), 64'd1);
        step();
        pend[0] = 1'b0;
        apply_reqs();
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        m_rvalid  = 1'b1;
        s0_rready = 1'b0;
        #1;
        check("rstdata_pending_rvalid", 64'(s0_rvalid), 64'd1);
        rst = 1'b0;
        #1;
        check("rstdata_in_reset_rvalid", 64'({s1_rvalid, s0_rvalid}), 64'd0);
        check("rstdata_in_reset_m_rready", 64'(m_rready), 64'd0);
        step();
        rst = 1'b1;
        model_last = 1;
        s0_rready = 1'b1;
        #1;
        check("rstdata_after_m_rready", 64'(m_rready), 64'd0);
        check("rstdata_after_rvalid", 64'({s1_rvalid, s0_rvalid}), 64'd0);
        check("rstdata_after_m_arvalid", 64'(m_arvalid), 64'd0);
        m_rvalid  = 1'b0;
        s0_rready = 1'b0;

        // ---- Randomized traffic ----
        for (int n = 0; n < 40; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && ($urandom_range(0, 2) != 0)) begin
                    pend[p] = 1'b1;
                    pend_addr[p] = AW'({$urandom_range(0, 'hFFFF), 2'b00});
                end
            end
            if (!pend[0] && !pend[1]) begin
                pend[n % 2] = 1'b1;
                pend_addr[n % 2] = AW'({$urandom_range(0, 'hFFFF), 2'b00});
            end
            ar_d = $urandom_range(0, 3);
            r_d  = $urandom_range(0, 3);
            rr_d = $urandom_range(0, 2);
            resp = 2'($urandom_range(0, 3));
            data = DW'($urandom);
            serve(ar_d, r_d, rr_d, resp, data, 1'b0, obs_g);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_axil_read_arbiter

// File: doc/axil_read_arbiter.md
Name: axil_read_arbiter

Overview:
- Shares one AXI4-lite read master channel between two requesters: the load path (s0) and the instruction fetch unit (s1).
- Accepts one request at a time, latches its address, and drives the address phase on the master channel.
- Routes the read response back only to the granted requester.
- Sits between the core fetch/memory stages and the system bus. Exactly one transaction is outstanding at a time.

Parameters:
- ADDR_W, default ADDR_WIDTH (core_pkg): address width.
- DATA_W, default DATA_WIDTH (core_pkg): read data width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-low reset
- s0_araddr  input  ADDR_W  load-path read address
- s0_arvalid  input  1  load-path address valid
- s0_arready  output  1  load-path address accepted
- s0_rdata  output  DATA_W  read data to load path
- s0_rresp  output  2  response code to load path
- s0_rvalid  output  1  response valid to load path
- s0_rready  input  1  load path ready for response
- s1_araddr, s1_arvalid, s1_arready, s1_rdata, s1_rresp, s1_rvalid, s1_rready: same widths and directions as s0; these are the instruction-fetch signals.
- m_araddr  output  ADDR_W  bus read address
- m_arprot  output  3  bus protection attribute
- m_arvalid  output  1  bus address valid
- m_arready  input  1  bus address ready
- m_rdata  input  DATA_W  bus read data
- m_rresp  input  2  bus response code
- m_rvalid  input  1  bus response valid
- m_rready  output  1  bus response ready

Behaviour:
- Reset (rst=0 at posedge clk) sets:
  - state=ARB_IDLE, grant=0, last_grant=1;
  - m_arvalid=0, m_rready=0, m_araddr=0, m_arprot=0;
  - s0/s1 arready=0 and rvalid=0.
- Reset mid-transaction abandons the transaction with no response delivered; the bus is reset alongside the core.
- State machine arb_state_t:
  - ARB_IDLE: if any sN_arvalid is high, the selected requester sees sN_arready=1 combinationally in the same cycle. In that cycle, latch araddr into addr_q, latch grant, and set arprot_q (s0 -> 3'b000, s1 -> 3'b100 instruction). Next state is ARB_ADDR. With no request, stay in ARB_IDLE.
  - ARB_ADDR: m_arvalid=1, m_araddr=addr_q, m_arprot=arprot_q; these are held stable until m_arready. On m_arvalid & m_arready, go to ARB_DATA.
  - ARB_DATA: m_rready equals the granted requester's rready. The granted requester's rvalid equals m_rvalid; the other requester's rvalid is 0. On m_rvalid & m_rready, set last_grant=grant and go to ARB_IDLE.
- rdata and rresp are broadcast unregistered to both requesters. Only rvalid is gated.
- Both arready outputs are 0 outside ARB_IDLE.
- The non-selected requester's arready is 0. It must hold arvalid/araddr per AXI rules until it is served.
- Latency, request accepted to m_arvalid: 1 cycle. Minimum full transaction: 3 cycles (IDLE, ADDR, DATA), since m_arready and m_rvalid may each arrive in the first cycle of their state.
- A new request is never accepted in the same cycle a response completes. IDLE is always visited for 1 cycle.
- Simultaneous s0/s1 arvalid are resolved per Optional Feature.
- Responses are passed through with no delay: backpressure on rready stalls in ARB_DATA indefinitely.
- m_rresp values (including SLVERR/DECERR) are forwarded unmodified. The arbiter does not retry.
- An m_rvalid arriving in ARB_IDLE or ARB_ADDR is ignored (m_rready=0).

Optional Feature:
- Macro: AXIL_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. On a simultaneous request, grant the requester not equal to last_grant. A single request is granted directly.
- Undefined: fixed priority, s0 (load) always wins. last_grant is still maintained but unused.

Decomposition:
- core_pkg gains:
  - typedef enum logic [1:0] arb_state_t {ARB_IDLE=2'b00, ARB_ADDR=2'b01, ARB_DATA=2'b10};
  - constants ARPROT_DATA=3'b000 and ARPROT_INSTR=3'b100.
- One sub-module, arb_grant_select:
  - purely combinational;
  - inputs req[1:0], last_grant;
  - outputs gnt_valid, gnt_idx;
  - contains the macro-dependent policy.
- All state and muxing stay in the top module.

Test Plan:
- Reset then idle: rst=0 for 2 cycles -> all valid/ready outputs 0. With no arvalid, m_arvalid stays 0 for 10 cycles.
- Single fetch: s1_araddr=0x0000_0004 with s1_arvalid=1 -> s1_arready=1 in the same cycle. Next cycle m_araddr=0x4, m_arprot=3'b100. Slave responds m_rdata=0x0010_0093, rresp=0 -> s1_rvalid=1 with s1_rdata=0x0010_0093, and s0_rvalid=0 throughout.
- Simultaneous requests: s0_araddr=0x100 and s1_araddr=0x8 both valid from reset. Without the macro, the order on m_araddr is 0x100 then 0x8. With AXIL_ARB_ROUND_ROBIN_EN, the first is 0x100 (last_grant=1 at reset) then 0x8. With both held continuously for 4 transactions, the RR build alternates s0, s1, s0, s1 and the fixed build is s0, s0, s0, s0.
- Backpressure: m_arready low for 3 cycles -> m_arvalid and m_araddr stay stable. Then s0_rready low for 2 cycles with m_rvalid high -> m_rready=0 and the arbiter stays in ARB_DATA; completion happens on the cycle s0_rready rises.
- Error and reset: m_rresp=2'b10 -> s0_rresp=2'b10 delivered. Separately, assert rst=0 while in ARB_DATA -> next cycle state is ARB_IDLE with m_rready=0, and no rvalid is delivered.
